apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
- Two-requester APB master: shares the single APB bus (address decoder → SRAM / UART) between instruction fetch (port 0) and load/store unit (port 1).
- Arbitrates round-robin and latches the winner's request.
- Sequences APB IDLE/SETUP/ACCESS phases and returns read data / error to the winner with a one-cycle done pulse.
- Bounds wait states with a timeout, because the decoder never raises pready for unmapped addresses.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT, 255, max ACCESS cycles with pready=0 before forced error completion; 0 disables timeout.

Ports:
- pclk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  port 0 request; held until m0_done
- m0_addr  in  ADDR_WIDTH  port 0 address
- m0_wdata  in  DATA_WIDTH  port 0 write data
- m0_write  in  1  port 0 write=1 / read=0
- m0_stb  in  4  port 0 byte strobes
- m0_done  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_WIDTH  read data, valid with m0_done
- m0_err  out  1  error, valid with m0_done
- m1_req, m1_addr, m1_wdata, m1_write, m1_stb, m1_done, m1_rdata, m1_err: same as port 0, for port 1
- paddr  out  ADDR_WIDTH  APB address
- pdata  out  DATA_WIDTH  APB write data
- pwrite  out  1  APB direction
- pstb  out  4  APB strobes
- psel  out  1  APB select
- penable  out  1  APB enable
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- perr  in  1  APB error (combinational from decoder)

Behaviour:
- Reset:
  - Every output and register is 0.
  - State=IDLE, priority pointer=port 0, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible requester: mN_req=1 and mN_done not asserted this cycle. This masks the requester that just completed so a req still high one cycle later is not re-issued.
  - If none eligible: stay IDLE.
  - If one eligible: grant it.
  - If both eligible: grant the priority-pointer port.
  - On grant: latch that port's addr/wdata/write/stb into paddr/pdata/pwrite/pstb; record owner; psel←1, penable←0; go to SETUP; pointer←other port.
- SETUP: penable←1; counter←0; go to ACCESS. Lasts exactly one cycle.
- ACCESS: paddr/pdata/pwrite/pstb/psel held stable.
  - Completion when pready=1 OR perr=1 at the edge:
    - psel←0, penable←0; state←IDLE.
    - owner's done←1; owner's err←perr.
    - owner's rdata←prdata on a read; 0 on a write or when perr=1.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: forced completion; same as above with err←1, rdata←0.
  - Else: counter increments.
  - Counter width clog2(TIMEOUT+1); saturating behaviour is not required because the terminal compare always fires first.
- done pulses:
  - mN_done is high exactly one cycle; rdata/err are valid only in that cycle. rdata/err may hold stale values otherwise; benches check them only with done.
  - At most one done asserted per cycle.
  - The non-owner's outputs are untouched.
- Latency: req sampled in IDLE at edge k → SETUP cycle k+1, ACCESS k+2; with zero wait states done is high in cycle k+3. Minimum 3 cycles per transfer.
- Request fields only need to be valid in the granting IDLE cycle; later changes are ignored until the next grant.
- Back-to-back:
  - Earliest next grant is the cycle after done, for a different port the done cycle itself.
  - Peak throughput: one transfer per 3 cycles.
- Reset mid-transfer: at the next edge psel/penable drop; transfer aborted; no done pulse; pointer returns to port 0.
- Requester dropping req mid-transfer: no effect; transfer completes and done still pulses.

Test Plan:
- Single read, port 0: m0 reads addr 0x80000010, slave gives pready=1 first ACCESS cycle, prdata=0xDEADBEEF → psel high cycles k+1..k+2, penable k+2 only, m0_done=1 at k+3, m0_rdata=0xDEADBEEF, m0_err=0.
- Contention: m0 and m1 both request writes from reset, held continuously → grant order m0, m1, m0, m1; each port's second request issues only after its done; pwrite=1, pdata/pstb match owner each transfer.
- Wait states: m1 write to 0x1000000, pready low 4 ACCESS cycles then high → penable high 5 cycles with paddr/pdata stable, m1_done at 6th cycle after SETUP, m1_err=0.
- Decode error: m0 read 0x00000100, perr=1, pready=0 in first ACCESS cycle → completes immediately, m0_done=1, m0_err=1, m0_rdata=0.
- Timeout with TIMEOUT=8: slave never asserts pready/perr → exactly 8 ACCESS cycles, then psel/penable=0, m1_done=1, m1_err=1; the next m0 request is granted normally.
- Reset in ACCESS: assert rst during a waiting transfer → next cycle psel=penable=0, no done pulse; after release, a pending m1 and m0 request resolves to m0 first.

Source files
------------

// File: rtl/apb_master_arb_if.sv
// Bundle of both requester ports and the shared APB bus for apb_master_arb.
// The master modport is the arbiter's view; slave is the requester/APB environment view.
interface apb_master_arb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STB_W = 4;

    logic                  m0_req;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_write;
    logic [STB_W-1:0]      m0_stb;
    logic                  m0_done;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_err;

    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_write;
    logic [STB_W-1:0]      m1_stb;
    logic                  m1_done;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_err;

    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pdata;
    logic                  pwrite;
    logic [STB_W-1:0]      pstb;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  perr;

    modport master (
        input  m0_req, m0_addr, m0_wdata, m0_write, m0_stb,
        output m0_done, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_wdata, m1_write, m1_stb,
        output m1_done, m1_rdata, m1_err,
        output paddr, pdata, pwrite, pstb, psel, penable,
        input  prdata, pready, perr
    );

    modport slave (
        output m0_req, m0_addr, m0_wdata, m0_write, m0_stb,
        input  m0_done, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_wdata, m1_write, m1_stb,
        input  m1_done, m1_rdata, m1_err,
        input  paddr, pdata, pwrite, pstb, psel, penable,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_master_arb.sv
// Two-port round-robin APB master: latches the winning request, runs SETUP/ACCESS,
// and returns rdata/err with a one-cycle done pulse; wait states bounded by TIMEOUT.
module apb_master_arb #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic pclk,
    input logic rst,
    apb_master_arb_if.master bus
);
    localparam int unsigned STB_W    = 4;
    localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [STB_W-1:0]      pstb_q, pstb_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  m0_done_q, m0_done_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic                  m0_err_q, m0_err_d;
    logic                  m1_done_q, m1_done_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  m1_err_q, m1_err_d;

    logic                  elig0_c, elig1_c, grant1_c;
    logic                  xfer_done_c, xfer_err_c;
    logic [DATA_WIDTH-1:0] xfer_rdata_c;

    // A port whose done is high this cycle is masked so its still-high req is not re-issued.
    assign elig0_c  = bus.m0_req & ~m0_done_q;
    assign elig1_c  = bus.m1_req & ~m1_done_q;
    assign grant1_c = elig1_c & (~elig0_c | ptr_q);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        paddr_d      = paddr_q;
        pdata_d      = pdata_q;
        pwrite_d     = pwrite_q;
        pstb_d       = pstb_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        m0_done_d    = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m0_err_d     = m0_err_q;
        m1_done_d    = 1'b0;
        m1_rdata_d   = m1_rdata_q;
        m1_err_d     = m1_err_q;
        xfer_done_c  = 1'b0;
        xfer_err_c   = 1'b0;
        xfer_rdata_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (elig0_c || elig1_c) begin
                    if (grant1_c) begin
                        paddr_d  = bus.m1_addr;
                        pdata_d  = bus.m1_wdata;
                        pwrite_d = bus.m1_write;
                        pstb_d   = bus.m1_stb;
                    end else begin
                        paddr_d  = bus.m0_addr;
                        pdata_d  = bus.m0_wdata;
                        pwrite_d = bus.m0_write;
                        pstb_d   = bus.m0_stb;
                    end
                    owner_d   = grant1_c;
                    ptr_d     = ~grant1_c;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready || bus.perr) begin
                    xfer_done_c  = 1'b1;
                    xfer_err_c   = bus.perr;
                    xfer_rdata_c = (!pwrite_q && !bus.perr) ? bus.prdata : '0;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST))) begin
                    // Unmapped addresses never see pready; force an error completion.
                    xfer_done_c = 1'b1;
                    xfer_err_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (xfer_done_c) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Only the owner's return registers change; the other port keeps its values.
        if (xfer_done_c) begin
            if (owner_q) begin
                m1_done_d  = 1'b1;
                m1_err_d   = xfer_err_c;
                m1_rdata_d = xfer_rdata_c;
            end else begin
                m0_done_d  = 1'b1;
                m0_err_d   = xfer_err_c;
                m0_rdata_d = xfer_rdata_c;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            paddr_q    <= '0;
            pdata_q    <= '0;
            pwrite_q   <= 1'b0;
            pstb_q     <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            m0_done_q  <= 1'b0;
            m0_rdata_q <= '0;
            m0_err_q   <= 1'b0;
            m1_done_q  <= 1'b0;
            m1_rdata_q <= '0;
            m1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            paddr_q    <= paddr_d;
            pdata_q    <= pdata_d;
            pwrite_q   <= pwrite_d;
            pstb_q     <= pstb_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            m0_done_q  <= m0_done_d;
            m0_rdata_q <= m0_rdata_d;
            m0_err_q   <= m0_err_d;
            m1_done_q  <= m1_done_d;
            m1_rdata_q <= m1_rdata_d;
            m1_err_q   <= m1_err_d;
        end
    end

    assign bus.paddr    = paddr_q;
    assign bus.pdata    = pdata_q;
    assign bus.pwrite   = pwrite_q;
    assign bus.pstb     = pstb_q;
    assign bus.psel     = psel_q;
    assign bus.penable  = penable_q;
    assign bus.m0_done  = m0_done_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m0_err   = m0_err_q;
    assign bus.m1_done  = m1_done_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.m1_err   = m1_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with a per-port scoreboard of expected completions.
module tb_apb_master_arb;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic pclk;
    logic rst;

    apb_master_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] c_addr[4] = '{32'h8000_0100, 32'h0100_0200, 32'h8000_0104, 32'h0100_0204};
    logic [31:0] c_data[4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    logic [3:0]  c_stb[4]  = '{4'h3, 4'hC, 4'h1, 4'h8};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (bus.m0_done || bus.m1_done)
            chk("single_done", 64'(bus.m0_done & bus.m1_done), 64'(0));
        if (bus.m0_done) begin
            chk("m0_done_expected", 64'(exp0.size() > 0), 64'(1));
            if (exp0.size() > 0) begin
                e = exp0.pop_front();
                chk("m0_rdata", 64'(bus.m0_rdata), 64'(e.rdata));
                chk("m0_err", 64'(bus.m0_err), 64'(e.err));
            end
        end
        if (bus.m1_done) begin
            chk("m1_done_expected", 64'(exp1.size() > 0), 64'(1));
            if (exp1.size() > 0) begin
                e = exp1.pop_front();
                chk("m1_rdata", 64'(bus.m1_rdata), 64'(e.rdata));
                chk("m1_err", 64'(bus.m1_err), 64'(e.err));
            end
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        sb_check();
    endtask

    task automatic set_req(input int port, input logic req, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic wr, input logic [3:0] stb);
        if (port == 0) begin
            bus.m0_req = req; bus.m0_addr = addr; bus.m0_wdata = wdata;
            bus.m0_write = wr; bus.m0_stb = stb;
        end else begin
            bus.m1_req = req; bus.m1_addr = addr; bus.m1_wdata = wdata;
            bus.m1_write = wr; bus.m1_stb = stb;
        end
    endtask

    // One transfer from an idle bus; slave answers after `waits` low-pready ACCESS cycles.
    task automatic xfer(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wr, input logic [3:0] stb, input int waits,
                        input logic err_resp, input logic [31:0] rd);
        exp_t e;
        e.rdata = (wr || err_resp) ? 32'h0 : rd;
        e.err   = err_resp;
        if (port == 0) exp0.push_back(e); else exp1.push_back(e);
        set_req(port, 1'b1, addr, wdata, wr, stb);
        tick();
        chk("setup_psel", 64'(bus.psel), 64'(1));
        chk("setup_penable", 64'(bus.penable), 64'(0));
        chk("setup_paddr", 64'(bus.paddr), 64'(addr));
        chk("setup_pdata", 64'(bus.pdata), 64'(wdata));
        chk("setup_pwrite", 64'(bus.pwrite), 64'(wr));
        chk("setup_pstb", 64'(bus.pstb), 64'(stb));
        set_req(port, 1'b1, ~addr, ~wdata, ~wr, ~stb);
        tick();
        for (int i = 0; i < waits; i++) begin
            chk("wait_penable", 64'(bus.penable), 64'(1));
            chk("wait_paddr", 64'(bus.paddr), 64'(addr));
            chk("wait_pdata", 64'(bus.pdata), 64'(wdata));
            chk("wait_no_done", 64'({bus.m0_done, bus.m1_done}), 64'(0));
            tick();
        end
        chk("access_psel", 64'(bus.psel), 64'(1));
        chk("access_penable", 64'(bus.penable), 64'(1));
        bus.pready = ~err_resp;
        bus.perr   = err_resp;
        bus.prdata = rd;
        tick();
        chk("done_port", 64'((port == 0) ? bus.m0_done : bus.m1_done), 64'(1));
        chk("done_psel", 64'(bus.psel), 64'(0));
        chk("done_penable", 64'(bus.penable), 64'(0));
        set_req(port, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        bus.pready = 1'b0;
        bus.perr   = 1'b0;
        bus.prdata = 32'h0;
    endtask

    initial begin
        exp_t e;
        int   owner;
        rst = 1'b1;
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        bus.pready = 1'b0;
        bus.perr   = 1'b0;
        bus.prdata = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst_psel", 64'(bus.psel), 64'(0));
        chk("rst_penable", 64'(bus.penable), 64'(0));
        chk("rst_paddr", 64'(bus.paddr), 64'(0));
        chk("rst_pdata", 64'(bus.pdata), 64'(0));
        chk("rst_pwrite", 64'(bus.pwrite), 64'(0));
        chk("rst_pstb", 64'(bus.pstb), 64'(0));
        chk("rst_m0", 64'({bus.m0_done, bus.m0_err, bus.m0_rdata}), 64'(0));
        chk("rst_m1", 64'({bus.m1_done, bus.m1_err, bus.m1_rdata}), 64'(0));
        rst = 1'b0;

        // Single read on port 0, zero wait states
        xfer(0, 32'h8000_0010, 32'h0, 1'b0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
        tick();
        chk("done_one_cycle", 64'({bus.m0_done, bus.m1_done}), 64'(0));

        // Contention from reset: both ports hold write requests
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        exp0.push_back(e); exp0.push_back(e);
        exp1.push_back(e); exp1.push_back(e);
        set_req(0, 1'b1, c_addr[0], c_data[0], 1'b1, c_stb[0]);
        set_req(1, 1'b1, c_addr[1], c_data[1], 1'b1, c_stb[1]);
        bus.pready = 1'b1;
        bus.prdata = 32'hFFFF_FFFF;
        for (int t = 0; t < 4; t++) begin
            owner = t % 2;
            tick();
            chk("rr_setup_psel", 64'({bus.psel, bus.penable}), 64'(2));
            chk("rr_paddr", 64'(bus.paddr), 64'(c_addr[t]));
            chk("rr_pdata", 64'(bus.pdata), 64'(c_data[t]));
            chk("rr_pstb", 64'(bus.pstb), 64'(c_stb[t]));
            chk("rr_pwrite", 64'(bus.pwrite), 64'(1));
            if (t < 2) set_req(owner, 1'b1, c_addr[t+2], c_data[t+2], 1'b1, c_stb[t+2]);
            tick();
            chk("rr_access_paddr", 64'(bus.paddr), 64'(c_addr[t]));
            tick();
            chk("rr_done", 64'({bus.m1_done, bus.m0_done}), 64'((owner == 0) ? 1 : 2));
        end
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        bus.pready = 1'b0;
        bus.prdata = 32'h0;
        tick();
        chk("rr_idle_psel", 64'(bus.psel), 64'(0));

        // Wait states on port 1 write
        xfer(1, 32'h0100_0000, 32'hA5A5_5A5A, 1'b1, 4'hF, 4, 1'b0, 32'h1111_2222);

        // Decode error on port 0 read
        xfer(0, 32'h0000_0100, 32'h0, 1'b0, 4'hF, 0, 1'b1, 32'h1234_5678);

        // Timeout: slave never responds
        e.rdata = 32'h0;
        e.err   = 1'b1;
        exp1.push_back(e);
        set_req(1, 1'b1, 32'h2000_0000, 32'h0, 1'b0, 4'hF);
        bus.prdata = 32'hBAD0_BAD0;
        tick();
        chk("to_setup", 64'({bus.psel, bus.penable}), 64'(2));
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        for (int i = 0; i < int'(TO); i++) begin
            tick();
            chk("to_access", 64'({bus.psel, bus.penable}), 64'(3));
            chk("to_no_done", 64'(bus.m1_done), 64'(0));
        end
        tick();
        chk("to_done", 64'(bus.m1_done), 64'(1));
        chk("to_bus_idle", 64'({bus.psel, bus.penable}), 64'(0));
        bus.prdata = 32'h0;
        xfer(0, 32'h8000_0020, 32'h0, 1'b0, 4'hF, 0, 1'b0, 32'hCAFE_F00D);

        // Reset while a transfer waits in ACCESS
        set_req(1, 1'b1, 32'h3000_0000, 32'h0, 1'b0, 4'hF);
        tick();
        tick();
        tick();
        chk("rst_mid_access", 64'(bus.penable), 64'(1));
        rst = 1'b1;
        set_req(0, 1'b1, 32'h8000_0040, 32'h0, 1'b0, 4'hF);
        tick();
        chk("rst_mid_bus", 64'({bus.psel, bus.penable}), 64'(0));
        chk("rst_mid_no_done", 64'({bus.m0_done, bus.m1_done}), 64'(0));
        rst = 1'b0;
        e.rdata = 32'h55AA_0001;
        e.err   = 1'b0;
        exp0.push_back(e);
        tick();
        chk("post_rst_m0_first", 64'(bus.paddr), 64'(32'h8000_0040));
        bus.pready = 1'b1;
        bus.prdata = 32'h55AA_0001;
        tick();
        tick();
        chk("post_rst_m0_done", 64'(bus.m0_done), 64'(1));
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        e.rdata = 32'h66BB_0002;
        exp1.push_back(e);
        bus.prdata = 32'h66BB_0002;
        tick();
        chk("post_rst_m1_next", 64'(bus.paddr), 64'(32'h3000_0000));
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        tick();
        tick();
        chk("post_rst_m1_done", 64'(bus.m1_done), 64'(1));
        bus.pready = 1'b0;
        bus.prdata = 32'h0;
        tick();
        tick();

        chk("sb_empty", 64'(exp0.size() + exp1.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
